settings_ctrl: RTL and testbench

Settings controller that turns raw board switches and an Apply push-button into committed game configuration. It synchronises and debounces the inputs and validates the requested mode. It commits mode/level/speed onto the `producer` modport of the settings interface only while the game is not running. It sits directly upstream of the game logic, which reads the same interface through its `consumer` modport.

---
 rtl/settings_pkg.sv | 25 ++
 rtl/settings_if.sv | 9 +
 rtl/settings_debounce.sv | 48 ++++
 rtl/settings_ctrl.sv | 137 +++++++++++++
 tb/tb_settings_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/settings_pkg.sv
// Shared types and constants for the settings controller and its consumers.
package settings_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      COMMIT = 2'd2,
      LOCKED = 2'd3
   } settings_state_t;

   localparam logic [1:0] MODE_SOLO  = 2'b00;
   localparam logic [1:0] MODE_TWO   = 2'b01;
   localparam logic [1:0] MODE_RSVD2 = 2'b10;
   localparam logic [1:0] MODE_RSVD3 = 2'b11;

   localparam logic [1:0] LEVEL_EASY = 2'b00;
   localparam logic [1:0] LEVEL_HARD = 2'b01;
   localparam logic [1:0] SPEED_SLOW = 2'b00;
   localparam logic [1:0] SPEED_FAST = 2'b01;

   function automatic logic mode_is_valid(input logic [1:0] mode);
      return (mode == MODE_SOLO) || (mode == MODE_TWO);
   endfunction

endpackage

// File: rtl/settings_if.sv
// Committed game configuration, driven by the settings controller and read by game logic.
interface settings_if;
   logic [1:0] mode;
   logic [1:0] level;
   logic [1:0] speed;

   modport producer (output mode, output level, output speed);
   modport consumer (input mode, input level, input speed);
endinterface

// File: rtl/settings_debounce.sv
// Single-bit 2-FF synchroniser followed by a consecutive-sample debouncer.
module settings_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             dout_q, dout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      dout_d  = dout_q;
      cnt_d   = '0;
      // The counter only survives while the sample keeps disagreeing with the output.
      if (sync2_q != dout_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            dout_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         dout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/settings_ctrl.sv
// Debounces board switches and the Apply button, validates the mode and commits settings while idle.
// state  | meaning
// IDLE   | waiting for an apply request, settings may change
// CHECK  | staged switches being validated
// COMMIT | new configuration written, cfg_updated pulse
// LOCKED | game running, apply requests ignored
module settings_ctrl
   import settings_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   sw_mode,
   input  logic         sw_level,
   input  logic         sw_speed,
   input  logic         btn_apply,
   input  logic         game_busy,
   settings_if.producer cfg,
   output logic         cfg_updated,
   output logic         cfg_reject,
   output logic         locked
);

   logic [4:0] raw;
   logic [4:0] db;
   logic       apply_req;

   settings_state_t state_q, state_d;
   logic [1:0] stage_mode_q, stage_mode_d;
   logic       stage_level_q, stage_level_d;
   logic       stage_speed_q, stage_speed_d;
   logic [1:0] mode_q, mode_d;
   logic       level_q, level_d;
   logic       speed_q, speed_d;
   logic       btn_prev_q, btn_prev_d;
   logic       updated_q, updated_d;
   logic       reject_q, reject_d;
   logic       locked_q, locked_d;

   assign raw = {btn_apply, sw_speed, sw_level, sw_mode};

   for (genvar i = 0; i < 5; i++) begin : g_db
      settings_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_db (
         .clk  (clk),
         .rst  (rst),
         .din  (raw[i]),
         .dout (db[i])
      );
   end

   assign apply_req = db[4] & ~btn_prev_q;

   always_comb begin
      state_d       = state_q;
      stage_mode_d  = stage_mode_q;
      stage_level_d = stage_level_q;
      stage_speed_d = stage_speed_q;
      mode_d        = mode_q;
      level_d       = level_q;
      speed_d       = speed_q;
      btn_prev_d    = db[4];
      updated_d     = 1'b0;
      reject_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A busy game wins over a simultaneous request; the request is lost.
            if (game_busy) begin
               state_d = LOCKED;
            end else if (apply_req) begin
               state_d       = CHECK;
               stage_mode_d  = db[1:0];
               stage_level_d = db[2];
               stage_speed_d = db[3];
            end
         end
         CHECK: begin
            if (game_busy) begin
               state_d = LOCKED;
            end else if (!mode_is_valid(stage_mode_q)) begin
               state_d  = IDLE;
               reject_d = 1'b1;
            end else begin
               state_d   = COMMIT;
               mode_d    = stage_mode_q;
               level_d   = stage_level_q;
               speed_d   = stage_speed_q;
               updated_d = 1'b1;
            end
         end
         COMMIT: state_d = game_busy ? LOCKED : IDLE;
         LOCKED: if (!game_busy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         stage_mode_q  <= 2'b00;
         stage_level_q <= 1'b0;
         stage_speed_q <= 1'b0;
         mode_q        <= MODE_SOLO;
         level_q       <= 1'b0;
         speed_q       <= 1'b0;
         btn_prev_q    <= 1'b0;
         updated_q     <= 1'b0;
         reject_q      <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         stage_mode_q  <= stage_mode_d;
         stage_level_q <= stage_level_d;
         stage_speed_q <= stage_speed_d;
         mode_q        <= mode_d;
         level_q       <= level_d;
         speed_q       <= speed_d;
         btn_prev_q    <= btn_prev_d;
         updated_q     <= updated_d;
         reject_q      <= reject_d;
         locked_q      <= locked_d;
      end
   end

   assign cfg.mode    = mode_q;
   assign cfg.level   = level_q ? LEVEL_HARD : LEVEL_EASY;
   assign cfg.speed   = speed_q ? SPEED_FAST : SPEED_SLOW;
   assign cfg_updated = updated_q;
   assign cfg_reject  = reject_q;
   assign locked      = locked_q;

endmodule

// File: tb/tb_settings_ctrl.sv
// Self-checking bench for settings_ctrl: vector table, directed corner cases and random traffic vs a reference model.
module tb_settings_ctrl;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] sw_mode = 2'b00;
   logic       sw_level = 1'b0;
   logic       sw_speed = 1'b0;
   logic       btn_apply = 1'b0;
   logic       game_busy = 1'b0;
   logic       cfg_updated, cfg_reject, locked;

   settings_if cfg_if ();

   settings_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .sw_mode     (sw_mode),
      .sw_level    (sw_level),
      .sw_speed    (sw_speed),
      .btn_apply   (btn_apply),
      .game_busy   (game_busy),
      .cfg         (cfg_if),
      .cfg_updated (cfg_updated),
      .cfg_reject  (cfg_reject),
      .locked      (locked)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int upd_cnt = 0;
   int rej_cnt = 0;

   // Reference model: raw sample history, debounced values, pending apply phase.
   logic [4:0] hist [0:D+1];
   logic [4:0] db_m, db_prev_m, stage_m;
   int         ph;
   logic [1:0] mode_m, level_m, speed_m;
   logic       upd_m, rej_m, locked_m;

   typedef struct {
      logic [1:0] mode;
      logic       level;
      logic       speed;
      logic       busy;
      int         exp_upd;
      int         exp_rej;
      logic [5:0] exp_cfg;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [8:0] dut_obs();
      return {cfg_if.mode, cfg_if.level, cfg_if.speed, cfg_updated, cfg_reject, locked};
   endfunction

   function automatic logic [5:0] dut_cfg();
      return {cfg_if.mode, cfg_if.level, cfg_if.speed};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i <= D + 1; i++) hist[i] = '0;
      db_m = '0; db_prev_m = '0; stage_m = '0; ph = 0;
      mode_m = '0; level_m = '0; speed_m = '0;
      upd_m = 1'b0; rej_m = 1'b0; locked_m = 1'b0;
   endtask

   task automatic model_step();
      logic [4:0] raw;
      logic       apply;
      logic       all_eq;
      raw   = {btn_apply, sw_speed, sw_level, sw_mode};
      apply = db_m[4] && !db_prev_m[4];
      upd_m = 1'b0;
      rej_m = 1'b0;
      if (ph == 1) begin
         ph = 0;
         if (!game_busy) begin
            if (stage_m[1:0] >= 2) rej_m = 1'b1;
            else begin
               mode_m  = stage_m[1:0];
               level_m = {1'b0, stage_m[2]};
               speed_m = {1'b0, stage_m[3]};
               upd_m   = 1'b1;
               ph      = 2;
            end
         end
      end else if (ph == 2) begin
         ph = 0;
      end else if (!locked_m && !game_busy && apply) begin
         ph      = 1;
         stage_m = db_m;
      end
      // The controller is locked exactly when busy was seen on the previous edge.
      locked_m  = game_busy;
      db_prev_m = db_m;
      for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = raw;
      for (int b = 0; b < 5; b++) begin
         all_eq = 1'b1;
         for (int k = 2; k <= D + 1; k++) if (hist[k][b] != hist[2][b]) all_eq = 1'b0;
         if (all_eq) db_m[b] = hist[2][b];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      if (cfg_updated) upd_cnt++;
      if (cfg_reject) rej_cnt++;
      check("model", 16'(dut_obs()),
            16'({mode_m, level_m, speed_m, upd_m, rej_m, locked_m}));
   endtask

   task automatic async_reset(input int hold);
      #2 rst = 1'b1;
      #1 check("async_rst_outputs", 16'(dut_obs()), 16'h0);
      model_reset();
      repeat (hold) tick();
      rst = 1'b0;
   endtask

   task automatic set_sw(input logic [1:0] m, input logic l, input logic s);
      sw_mode = m; sw_level = l; sw_speed = s;
      repeat (10) tick();
   endtask

   task automatic busy_race(input int at);
      int u0, r0;
      set_sw(2'b01, 1'b0, 1'b0);
      u0 = upd_cnt; r0 = rej_cnt;
      btn_apply = 1'b1;
      repeat (at) tick();
      game_busy = 1'b1;
      repeat (3) tick();
      check("race_locked", 16'(locked), 16'h1);
      btn_apply = 1'b0;
      repeat (8) tick();
      game_busy = 1'b0;
      tick();
      check("race_unlocked", 16'(locked), 16'h0);
      repeat (10) tick();
      check("race_upd", 16'(upd_cnt - u0), 16'h0);
      check("race_rej", 16'(rej_cnt - r0), 16'h0);
      check("race_cfg", 16'(dut_cfg()), 16'h05);
   endtask

   initial begin
      int u0, r0;
      vecs[0] = '{2'b00, 1'b0, 1'b1, 1'b0, 1, 0, 6'b00_00_01};
      vecs[1] = '{2'b11, 1'b1, 1'b1, 1'b0, 0, 1, 6'b00_00_01};
      vecs[2] = '{2'b10, 1'b0, 1'b0, 1'b0, 0, 1, 6'b00_00_01};
      vecs[3] = '{2'b01, 1'b1, 1'b0, 1'b1, 0, 0, 6'b00_00_01};
      vecs[4] = '{2'b01, 1'b1, 1'b0, 1'b0, 1, 0, 6'b01_01_00};
      vecs[5] = '{2'b00, 1'b1, 1'b1, 1'b0, 1, 0, 6'b00_01_01};

      model_reset();
      repeat (2) tick();
      check("reset_state", 16'(dut_obs()), 16'h0);
      rst = 1'b0;

      // Basic commit latency: press in cycle N, cfg visible in N+8.
      set_sw(2'b01, 1'b1, 1'b1);
      u0 = upd_cnt;
      btn_apply = 1'b1;
      repeat (7) tick();
      check("press+7_cfg", 16'(dut_cfg()), 16'h00);
      tick();
      check("press+8_cfg", 16'(dut_cfg()), 16'h15);
      check("press+8_upd", 16'(cfg_updated), 16'h1);
      repeat (2) tick();
      btn_apply = 1'b0;
      repeat (10) tick();
      check("hold_one_upd", 16'(upd_cnt - u0), 16'h1);

      // Bounces of 1..3 cycles, then a clean press.
      u0 = upd_cnt;
      for (int w = 1; w <= 3; w++) begin
         btn_apply = 1'b1;
         repeat (w) tick();
         btn_apply = 1'b0;
         repeat (2) tick();
      end
      repeat (6) tick();
      check("bounce_no_upd", 16'(upd_cnt - u0), 16'h0);
      btn_apply = 1'b1;
      repeat (6) tick();
      btn_apply = 1'b0;
      repeat (10) tick();
      check("clean_one_upd", 16'(upd_cnt - u0), 16'h1);

      for (int v = 0; v < 6; v++) begin
         game_busy = vecs[v].busy;
         set_sw(vecs[v].mode, vecs[v].level, vecs[v].speed);
         u0 = upd_cnt; r0 = rej_cnt;
         btn_apply = 1'b1;
         repeat (6) tick();
         btn_apply = 1'b0;
         repeat (10) tick();
         check($sformatf("vec%0d_locked", v), 16'(locked), 16'(vecs[v].busy));
         game_busy = 1'b0;
         tick();
         check($sformatf("vec%0d_unlock", v), 16'(locked), 16'h0);
         repeat (10) tick();
         check($sformatf("vec%0d_upd", v), 16'(upd_cnt - u0), 16'(vecs[v].exp_upd));
         check($sformatf("vec%0d_rej", v), 16'(rej_cnt - r0), 16'(vecs[v].exp_rej));
         check($sformatf("vec%0d_cfg", v), 16'(dut_cfg()), 16'(vecs[v].exp_cfg));
      end

      // Busy rising with apply_req (N+6) and in the CHECK cycle (N+7).
      busy_race(6);
      busy_race(7);

      // Reset during a debounce count with the button held across it.
      set_sw(2'b01, 1'b1, 1'b1);
      btn_apply = 1'b1;
      repeat (3) tick();
      async_reset(2);
      u0 = upd_cnt;
      repeat (15) tick();
      check("rst_db_one_upd", 16'(upd_cnt - u0), 16'h1);
      check("rst_db_cfg", 16'(dut_cfg()), 16'h15);
      btn_apply = 1'b0;
      repeat (10) tick();

      // Reset during CHECK: the pending commit is lost, the held button re-applies once.
      set_sw(2'b00, 1'b0, 1'b1);
      btn_apply = 1'b1;
      repeat (7) tick();
      async_reset(2);
      u0 = upd_cnt;
      repeat (15) tick();
      check("rst_chk_one_upd", 16'(upd_cnt - u0), 16'h1);
      check("rst_chk_cfg", 16'(dut_cfg()), 16'h01);
      btn_apply = 1'b0;
      repeat (10) tick();

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 4) == 0) btn_apply = ~btn_apply;
         if ($urandom_range(0, 19) == 0) begin
            sw_mode  = 2'($urandom_range(0, 3));
            sw_level = 1'($urandom_range(0, 1));
            sw_speed = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 29) == 0) game_busy = ~game_busy;
         if ($urandom_range(0, 599) == 0) async_reset(2);
         else tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
